// File: rtl/perm_data_inject.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : perm_data_inject
// Description : Transmit end of the permutation network. Buffers producer
//               words headed for other slices and launches them onto stage 0
//               of the per-slice mux chain. The per-stage select vector is
//               dest ^ SLICE_ID. Credit-based flow control toward the network,
//               ready/valid toward the producer.
// Ports       : clk, reset          clock / synchronous active-high reset
//               s_valid/s_ready     producer handshake
//               s_dat/s_dest        producer payload and destination slice
//               flush               clear buffered words (credits kept)
//               t_valid/t_dat/sel   launch strobe, payload, stage selects
//               credit_ret          one credit returned by the network
//               credit_cnt          current credit count
//               err                 sticky credit overflow / push-while-full
//               t_par, t_par_err_inj  only with PERM_INJECT_PARITY_EN defined
// Options     : `define PERM_INJECT_PARITY_EN adds even parity over t_dat.
// Revision    : 1.0 - initial release
// ============================================================================
module perm_data_inject #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2SLICES = 3,
  parameter int SLICE_ID   = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_dat,
  input  logic [LOG2SLICES-1:0] s_dest,
  input  logic                  flush,
  output logic                  t_valid,
  output logic [DATA_WIDTH-1:0] t_dat,
  output logic [LOG2SLICES-1:0] sel,
  input  logic                  credit_ret,
  output logic [3:0]            credit_cnt,
  output logic                  err
`ifdef PERM_INJECT_PARITY_EN
  ,
  output logic                  t_par,
  input  logic                  t_par_err_inj
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + LOG2SLICES;
  localparam logic [3:0]            CREDITS_MAX = 4'(CREDITS);
  localparam logic [LOG2SLICES-1:0] SLICE_SEL   = LOG2SLICES'(SLICE_ID);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, occ, occ_nx;
  logic                  full, empty, push, pop, ovf;
  logic [3:0]            cnt_nx;
  logic [DATA_WIDTH-1:0] head_dat;
  logic [LOG2SLICES-1:0] head_dest;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign occ   = wr_ptr - rd_ptr;

  assign {head_dest, head_dat} = mem[rd_ptr[AW-1:0]];

  // Issue the head word; flush wins over any issue in the same cycle.
  assign pop = (state == SEND) && !empty && (credit_cnt != 4'd0) && !flush;

  // A full buffer still accepts a word in a cycle where the head is leaving,
  // so a push and pop together keep occupancy unchanged.
  assign s_ready = !reset && (!full || pop);
  assign push    = s_valid && s_ready && !flush;

  assign occ_nx = occ + (AW+1)'(push) - (AW+1)'(pop);

  // Credit counter: simultaneous issue and return cancel out.
  always_comb begin
    cnt_nx = credit_cnt;
    ovf    = 1'b0;
    if (pop && !credit_ret) begin
      cnt_nx = credit_cnt - 4'd1;
    end else if (credit_ret && !pop) begin
      if (credit_cnt >= CREDITS_MAX) ovf = 1'b1;
      else                           cnt_nx = credit_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!flush && !empty) state_nx = SEND;
      SEND: begin
        if (flush)                state_nx = IDLE;
        else if (occ_nx == '0)    state_nx = IDLE;
        else if (cnt_nx == 4'd0)  state_nx = STALL;
      end
      STALL: begin
        if (flush)                   state_nx = IDLE;
        else if (credit_cnt != 4'd0) state_nx = SEND;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Storage array carries no reset; pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_dest, s_dat};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      t_valid    <= 1'b0;
      t_dat      <= '0;
      sel        <= '0;
      credit_cnt <= CREDITS_MAX;
      err        <= 1'b0;
`ifdef PERM_INJECT_PARITY_EN
      t_par      <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      credit_cnt <= cnt_nx;
      // The push-while-full term is unreachable through the handshake and
      // acts as an internal consistency alarm.
      if (ovf || (push && full && !pop)) err <= 1'b1;
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      t_valid <= pop;
      if (pop) begin
        t_dat <= head_dat;
        sel   <= head_dest ^ SLICE_SEL;
`ifdef PERM_INJECT_PARITY_EN
        t_par <= (^head_dat) ^ t_par_err_inj;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perm_data_inject.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_perm_data_inject
// Description : Self-checking bench for perm_data_inject (SLICE_ID = 2).
//               Table-driven single-word launches plus hand sequences for
//               credit stall, full buffer, credit overflow, reset and flush.
//               A scoreboard queues accepted words and checks each launch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perm_data_inject;

  localparam int DW  = 32;
  localparam int LS  = 3;
  localparam int SID = 2;
  localparam int FD  = 4;
  localparam int CR  = 4;

  logic          clk = 1'b0;
  logic          reset, s_valid, s_ready, flush, t_valid, credit_ret, err;
  logic [DW-1:0] s_dat, t_dat;
  logic [LS-1:0] s_dest, sel;
  logic [3:0]    credit_cnt;
`ifdef PERM_INJECT_PARITY_EN
  logic          t_par, t_par_err_inj;
`endif

  always #5 clk = ~clk;

  perm_data_inject #(
    .DATA_WIDTH(DW), .LOG2SLICES(LS), .SLICE_ID(SID), .FIFO_DEPTH(FD), .CREDITS(CR)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_dat(s_dat), .s_dest(s_dest),
    .flush(flush),
    .t_valid(t_valid), .t_dat(t_dat), .sel(sel),
    .credit_ret(credit_ret), .credit_cnt(credit_cnt), .err(err)
`ifdef PERM_INJECT_PARITY_EN
    , .t_par(t_par), .t_par_err_inj(t_par_err_inj)
`endif
  );

  int tests = 0;
  int fails = 0;
  int tv_count = 0;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [LS-1:0] sel;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [DW-1:0] dat;
    logic [LS-1:0] dest;
    logic [LS-1:0] exp_sel;
    logic          exp_par;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: launches checked before the queue is cleared by reset/flush.
  always @(negedge clk) begin : mon
    exp_t e;
    if (t_valid === 1'b1) begin
      tv_count++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_launch: got t_dat=%0h sel=%0h, required no launch", t_dat, sel);
      end else begin
        e = sb.pop_front();
        chk("sb_t_dat", 64'(t_dat), 64'(e.dat));
        chk("sb_sel", 64'(sel), 64'(e.sel));
      end
    end
    if (reset || flush) begin
      sb.delete();
    end else if (s_valid && s_ready) begin
      e.dat = s_dat;
      e.sel = s_dest ^ LS'(SID);
      sb.push_back(e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; flush = 1'b0; credit_ret = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic give_credit();
    credit_ret = 1'b1;
    tick(1);
    credit_ret = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [LS-1:0] dst);
    int n;
    s_valid = 1'b1; s_dat = d; s_dest = dst;
    n = 0;
    while (s_ready !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("push_accepted", 64'(n < 20), 64'd1);
    if (n < 20) tick(1);
    s_valid = 1'b0;
  endtask

  task automatic wait_tv(output int lat);
    lat = 0;
    while (t_valid !== 1'b1 && lat < 12) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic wait_count(input int target);
    int n;
    n = 0;
    while (tv_count < target && n < 20) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int lat, base, n;
    vecs[0] = '{32'hA5A5_A5A5, 3'd5, 3'b111, 1'b0};
    vecs[1] = '{32'h0000_0007, 3'd2, 3'b000, 1'b1};
    vecs[2] = '{32'h1234_5678, 3'd0, 3'b010, 1'b1};
    vecs[3] = '{32'hFFFF_FFFF, 3'd7, 3'b101, 1'b0};
    vecs[4] = '{32'h0000_0000, 3'd3, 3'b001, 1'b0};

    reset = 1'b1; s_valid = 1'b0; flush = 1'b0; credit_ret = 1'b0;
    s_dat = '0; s_dest = '0;
`ifdef PERM_INJECT_PARITY_EN
    t_par_err_inj = 1'b0;
`endif
    tick(2);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_t_valid", 64'(t_valid), 64'd0);
    chk("rst_t_dat", 64'(t_dat), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_credit_cnt", 64'(credit_cnt), 64'd4);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b0;
    tick(1);
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);

    // Single-word launches from the table.
    for (int i = 0; i < 5; i++) begin
      chk("vec_cnt_before", 64'(credit_cnt), 64'd4);
      s_valid = 1'b1; s_dat = vecs[i].dat; s_dest = vecs[i].dest;
      tick(1);
      s_valid = 1'b0;
      wait_tv(lat);
      chk("vec_latency", 64'(lat), 64'd2);
      chk("vec_t_dat", 64'(t_dat), 64'(vecs[i].dat));
      chk("vec_sel", 64'(sel), 64'(vecs[i].exp_sel));
      chk("vec_cnt_after", 64'(credit_cnt), 64'd3);
`ifdef PERM_INJECT_PARITY_EN
      chk("vec_t_par", 64'(t_par), 64'(vecs[i].exp_par));
`endif
      tick(1);
      chk("vec_pulse", 64'(t_valid), 64'd0);
      chk("vec_hold_dat", 64'(t_dat), 64'(vecs[i].dat));
      chk("vec_hold_sel", 64'(sel), 64'(vecs[i].exp_sel));
      give_credit();
      chk("vec_cnt_ret", 64'(credit_cnt), 64'd4);
    end

    // Six words, no returns: four launch, then stall with two buffered.
    do_reset();
    base = tv_count;
    for (int i = 0; i < 6; i++) push_word(32'h1000_0000 + 32'(i), LS'(i));
    tick(8);
    chk("burst_launched", 64'(tv_count - base), 64'd4);
    chk("burst_cnt", 64'(credit_cnt), 64'd0);
    chk("burst_s_ready", 64'(s_ready), 64'd1);
    give_credit();
    wait_count(base + 5);
    chk("burst_fifth", 64'(tv_count - base), 64'd5);
    tick(4);
    chk("burst_no_sixth", 64'(tv_count - base), 64'd5);
    give_credit();
    wait_count(base + 6);
    chk("burst_sixth", 64'(tv_count - base), 64'd6);
    for (int i = 0; i < 4; i++) begin give_credit(); tick(1); end
    chk("burst_cnt_full", 64'(credit_cnt), 64'd4);
    chk("burst_err", 64'(err), 64'd0);

    // Fill the buffer while stalled, then push and pop in the same cycle.
    do_reset();
    base = tv_count;
    for (int i = 0; i < 4; i++) push_word(32'h2000_0000 + 32'(i), 3'd1);
    tick(8);
    for (int i = 0; i < 4; i++) push_word(32'h3000_0000 + 32'(i), LS'(i + 4));
    tick(2);
    chk("full_s_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b1; s_dat = 32'h4444_4444; s_dest = 3'd6;
    tick(3);
    chk("hold_no_err", 64'(err), 64'd0);
    credit_ret = 1'b1;
    tick(1);
    credit_ret = 1'b0;
    n = 0;
    while (s_ready !== 1'b1 && n < 10) begin tick(1); n++; end
    chk("popush_ready", 64'(s_ready), 64'd1);
    tick(1);
    s_valid = 1'b0;
    tick(3);
    chk("popush_still_full", 64'(s_ready), 64'd0);
    chk("popush_err", 64'(err), 64'd0);
    chk("popush_cnt", 64'(credit_cnt), 64'd0);
    for (int i = 0; i < 8; i++) begin give_credit(); tick(3); end
    chk("drain_launched", 64'(tv_count - base), 64'd9);
    chk("drain_cnt", 64'(credit_cnt), 64'd4);
    chk("drain_sb", 64'(sb.size()), 64'd0);

    // Credit overflow is saturating and sticky; reset clears it.
    do_reset();
    give_credit();
    chk("ovf_cnt", 64'(credit_cnt), 64'd4);
    chk("ovf_err", 64'(err), 64'd1);
    tick(5);
    chk("ovf_sticky", 64'(err), 64'd1);

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) push_word(32'h5000_0000 + 32'(i), 3'd4);
    reset = 1'b1;
    tick(1);
    chk("midrst_t_valid", 64'(t_valid), 64'd0);
    chk("midrst_cnt", 64'(credit_cnt), 64'd4);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_t_dat", 64'(t_dat), 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    reset = 1'b0;
    base = tv_count;
    tick(6);
    chk("midrst_quiet", 64'(tv_count - base), 64'd0);
    chk("midrst_ready", 64'(s_ready), 64'd1);

    // Flush with three queued while stalled, plus a push in the flush cycle.
    do_reset();
    for (int i = 0; i < 4; i++) push_word(32'h6000_0000 + 32'(i), 3'd0);
    tick(8);
    for (int i = 0; i < 3; i++) push_word(32'h7000_0000 + 32'(i), 3'd5);
    tick(2);
    base = tv_count;
    flush = 1'b1; s_valid = 1'b1; s_dat = 32'hDEAD_BEEF; s_dest = 3'd1;
    tick(1);
    flush = 1'b0; s_valid = 1'b0;
    tick(1);
    chk("flush_cnt", 64'(credit_cnt), 64'd0);
    chk("flush_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin give_credit(); tick(1); end
    tick(4);
    chk("flush_no_launch", 64'(tv_count - base), 64'd0);
    chk("flush_cnt_back", 64'(credit_cnt), 64'd4);
    chk("flush_err", 64'(err), 64'd0);

    // Flush while words are launching: credits reflect only real launches.
    base = tv_count;
    for (int i = 0; i < 3; i++) push_word(32'h8000_0000 + 32'(i), 3'd3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(6);
    chk("flush_live_cnt", 64'(credit_cnt), 64'(4 - (tv_count - base)));
    chk("flush_live_sb", 64'(sb.size()), 64'd0);

`ifdef PERM_INJECT_PARITY_EN
    do_reset();
    t_par_err_inj = 1'b1;
    push_word(32'h0000_0007, 3'd2);
    wait_tv(lat);
    chk("par_inj", 64'(t_par), 64'd0);
    t_par_err_inj = 1'b0;
    push_word(32'h0000_0007, 3'd2);
    wait_tv(lat);
    chk("par_clean", 64'(t_par), 64'd1);
`endif

    tick(4);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
